iter_mul_div_unit: RTL and testbench

- Multi-cycle unsigned multiply/divide unit in the EX stage of the pipelined RV32 core.
- Sits beside the ripple adder and feeds its registered result into the EX result mux as an additional source.
- Implements MUL, MULHU, DIVU and REMU iteratively, one bit per cycle.
- Asserts busy so hazard logic can stall IF/ID/EX while an operation runs.

---
 rtl/iter_mul_div_unit.sv | 162 ++++++++++++++++
 tb/tb_iter_mul_div_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_mul_div_unit.sv
// iter_mul_div_unit
//   Multi-cycle unsigned multiply/divide unit for the EX stage of the RV32
//   pipeline. It computes one bit per cycle: shift-add for MUL/MULHU and
//   restoring division for DIVU/REMU. Its registered result feeds the EX
//   result mux as an extra source.
//
// Ports
//   clk        core clock; all state changes on the rising edge
//   rst        synchronous, active-high reset (priority over flush and start)
//   start      request an operation; sampled only in IDLE or DONE
//   op[1:0]    00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   rs1[N-1:0] operand A / dividend
//   rs2[N-1:0] operand B / divisor
//   flush      abort the running operation; blocks start in IDLE/DONE
//   busy       high while iterating (state RUN); used by hazard logic to stall
//   done       one-cycle pulse (state DONE); result is valid
//   result     registered result, held until the next operation completes
//   state_dbg  current FSM state, for checkers
//
// Handshake: start is a request with no ready. It is accepted on a rising
// edge where start=1, flush=0 and the state is IDLE or DONE. Acceptance moves
// the FSM to RUN and raises busy. Exactly N cycles later the FSM enters DONE
// for one cycle, and done marks that result is valid.
module iter_mul_div_unit #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] rs1,
  input  logic [N-1:0] rs2,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [1:0]   state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
  logic [N-1:0]  opnd_q, opnd_d;
  // Upper product half (multiply) or partial remainder (divide).
  logic [N-1:0]  hi_q, hi_d;
  // Multiplier shifting out / low product shifting in (multiply), or
  // dividend shifting out / quotient shifting in (divide).
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  result_q, result_d;
  logic          busy_q, done_q;

  logic [N:0]    mul_sum;
  logic [N:0]    div_shift;
  logic          div_ge;
  logic [N:0]    div_rem;
  logic [N-1:0]  it_hi, it_lo;
  logic          accept;

  // One iteration of the selected algorithm.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {N{1'b0}})};
    div_shift = {hi_q, lo_q[N-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_rem   = div_ge ? (div_shift - {1'b0, opnd_q}) : div_shift;
    if (op_q[1] == 1'b0) begin
      // Carry out of the add becomes the new top bit after the right shift.
      it_hi = mul_sum[N:1];
      it_lo = {mul_sum[0], lo_q[N-1:1]};
    end else begin
      // With a zero divisor every compare succeeds. The quotient then fills
      // with ones and the remainder ends as the dividend, which is the
      // RISC-V divide-by-zero result, so no special case is needed.
      it_hi = div_rem[N-1:0];
      it_lo = {lo_q[N-2:0], div_ge};
    end
  end

  assign accept = start && !flush && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          op_d    = op;
          cnt_d   = '0;
          hi_d    = '0;
          state_d = S_RUN;
          if (op[1]) begin
            opnd_d = rs2;
            lo_d   = rs1;
          end else begin
            opnd_d = rs1;
            lo_d   = rs2;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = it_hi;
          lo_d  = it_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = S_DONE;
            // MUL and DIVU take the low register; MULHU and REMU take the high one.
            result_d = op_q[0] ? it_hi : it_lo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      // Flopped straight from the next-state decode so the outputs cannot glitch.
      busy_q   <= (state_d == S_RUN);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_iter_mul_div_unit.sv
module tb_iter_mul_div_unit;

  localparam int N = 32;
  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] rs1;
  logic [N-1:0] rs2;
  logic         flush;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [1:0]   state_dbg;

  int checks   = 0;
  int failures = 0;

  iter_mul_div_unit #(.N(N), .CW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .done(done), .result(result),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    case (o)
      2'd0:    return p[N-1:0];
      2'd1:    return p[2*N-1:N];
      2'd2:    return (b == 0) ? {N{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation and waits for its done pulse. lat counts the edges
  // from the accepting edge to the edge that raises done. busy is high for
  // lat cycles and done for one more, so N+1 cycles in all. Operands are
  // scrambled right after acceptance to prove they were latched.
  task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] res, output int lat);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    wait_cycle();
    start = 1'b0;
    rs1 = $urandom; rs2 = $urandom; op = 2'($urandom_range(0, 3));
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      wait_cycle();
      lat++;
    end
    if (lat >= TIMEOUT) check("done_timeout", 32'(lat), 32'(N));
    res = result;
    wait_cycle();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  logic [N-1:0] res, res2, prev;
  int lat, gap, seen;

  initial begin
    vecs[0] = '{2'd0, 32'd7,          32'd6,          32'd42};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[2] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vecs[3] = '{2'd2, 32'd100,        32'd7,          32'd14};
    vecs[4] = '{2'd3, 32'd100,        32'd7,          32'd2};
    vecs[5] = '{2'd2, 32'd5,          32'd9,          32'd0};
    vecs[6] = '{2'd2, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF};
    vecs[7] = '{2'd3, 32'h0000_1234,  32'd0,          32'h0000_1234};
    vecs[8] = '{2'd1, 32'h8000_0000,  32'd4,          32'd2};
    vecs[9] = '{2'd3, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF};

    // ---------------- reset ----------------
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; rs1 = '0; rs2 = '0;
    wait_cycle();
    wait_cycle();
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    wait_cycle();

    // ---------------- directed table ----------------
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(N));
    end

    // ---------------- randomized against the model ----------------
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [N-1:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      exp_q.push_back(model(o, a, b));
      run_op(o, a, b, res, lat);
      check($sformatf("rand%0d_result", i), res, exp_q.pop_front());
    end

    // ---------------- start held high, back-to-back accept ----------------
    start = 1'b1; op = 2'd0; rs1 = 32'd3; rs2 = 32'd5;
    wait_cycle();
    lat = 0;
    // Changing operands with start still high must not disturb the running op.
    while (!done && lat < TIMEOUT) begin
      rs1 = $urandom; rs2 = $urandom; op = 2'($urandom_range(0, 3));
      wait_cycle();
      lat++;
    end
    check("b2b_first_latency", 32'(lat), 32'(N));
    check("b2b_first_result", result, 32'd15);
    // These operands are sampled on the edge that leaves DONE.
    op = 2'd2; rs1 = 32'd1000; rs2 = 32'd33;
    wait_cycle();
    check("b2b_reaccept_busy", {31'd0, busy}, 32'd1);
    start = 1'b0; rs1 = $urandom; rs2 = $urandom;
    gap = 1;
    while (!done && gap < TIMEOUT) begin
      wait_cycle();
      gap++;
    end
    check("b2b_done_spacing", 32'(gap), 32'(N + 1));
    check("b2b_second_result", result, 32'd30);
    wait_cycle();

    // ---------------- flush mid-RUN ----------------
    run_op(2'd0, 32'd7, 32'd6, prev, lat);
    start = 1'b1; op = 2'd2; rs1 = 32'hDEAD_BEEF; rs2 = 32'd3;
    wait_cycle();
    start = 1'b0;
    for (int i = 0; i < 10; i++) wait_cycle();
    flush = 1'b1;
    wait_cycle();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result_held", result, 32'd42);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      wait_cycle();
    end
    check("flush_no_done_pulse", 32'(seen), 32'd0);

    // ---------------- flush in DONE blocks start; flush in IDLE blocks start ----------------
    start = 1'b1; op = 2'd0; rs1 = 32'd9; rs2 = 32'd9;
    wait_cycle();
    start = 1'b0;
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      wait_cycle();
      lat++;
    end
    check("flushdone_result", result, 32'd81);
    start = 1'b1; flush = 1'b1; rs1 = 32'd2; rs2 = 32'd2;
    wait_cycle();
    check("flushdone_blocks_start", {31'd0, busy}, 32'd0);
    check("flushdone_no_second_done", {31'd0, done}, 32'd0);
    wait_cycle();
    check("flushidle_blocks_start", {31'd0, busy}, 32'd0);
    start = 1'b0; flush = 1'b0;
    wait_cycle();

    // ---------------- reset mid-RUN ----------------
    start = 1'b1; op = 2'd1; rs1 = 32'hFFFF_0000; rs2 = 32'h0001_0000;
    wait_cycle();
    start = 1'b0;
    for (int i = 0; i < 5; i++) wait_cycle();
    rst = 1'b1;
    wait_cycle();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);

    // One clean op after reset to show the unit recovers.
    run_op(2'd3, 32'd1000, 32'd7, res, lat);
    check("post_reset_remu", res, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
